// File: rtl/isa_pkg.sv
// Shared types and constants for the ISA sequencer: instruction layout, class codes, FSM states.
package isa_pkg;

    localparam int unsigned INSTR_W   = 20;
    localparam int unsigned CLS_W     = 2;
    localparam int unsigned ALUOP_W   = 3;
    localparam int unsigned FIELD_W   = 5;

    localparam int unsigned CLS_LSB   = 18;
    localparam int unsigned ALUOP_LSB = 15;
    localparam int unsigned RD_LSB    = 10;
    localparam int unsigned RS1_LSB   = 5;
    localparam int unsigned RS2_LSB   = 0;

    typedef enum logic [CLS_W-1:0] {
        CLS_ALU_BR  = 2'b00,
        CLS_ALU_RAM = 2'b01,
        CLS_NOP     = 2'b10,
        CLS_HALT    = 2'b11
    } cls_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE,
        ST_HALT
    } state_e;

    // Decoded view of one instruction word.
    typedef struct packed {
        cls_e               cls;
        logic [ALUOP_W-1:0] alu_op;
        logic [FIELD_W-1:0] rd;
        logic [FIELD_W-1:0] rs1;
        logic [FIELD_W-1:0] rs2;
    } instr_t;

endpackage

// File: rtl/isa_decode.sv
// Combinational field split of an instruction word into class, alu_op and register fields.
module isa_decode
    import isa_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output instr_t             o_fields
);

    always_comb begin
        o_fields        = '0;
        o_fields.cls    = cls_e'(i_instr[CLS_LSB +: CLS_W]);
        o_fields.alu_op = i_instr[ALUOP_LSB +: ALUOP_W];
        o_fields.rd     = i_instr[RD_LSB +: FIELD_W];
        o_fields.rs1    = i_instr[RS1_LSB +: FIELD_W];
        o_fields.rs2    = i_instr[RS2_LSB +: FIELD_W];
    end

endmodule

// File: rtl/isa_sequencer.sv
// Four-cycle READ/EXEC/WRITE controller for the register-bank / ALU / RAM datapath.
// All outputs are registered and computed from the next-state decision.
module isa_sequencer
    import isa_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned RAM_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [REG_AW-1:0]  op1,
    output logic [REG_AW-1:0]  op2,
    output logic [ALUOP_W-1:0] alu_op,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               we_br,
    output logic [REG_AW-1:0]  br_waddr,
    output logic               ram_we,
    output logic [RAM_AW-1:0]  ram_addr,
    output logic [DATA_W-1:0]  wdata,
    output logic               retire,
    output logic               halted,
    output logic [CNT_W-1:0]   retired_cnt
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [INSTR_W-1:0]   r_instr_q;
    logic [INSTR_W-1:0]   w_instr_q_nxt;
    logic [INSTR_W-1:0]   w_dec_src;
    instr_t               w_fields;

    logic                 r_instr_ready, w_instr_ready_nxt;
    logic [REG_AW-1:0]    r_op1, w_op1_nxt;
    logic [REG_AW-1:0]    r_op2, w_op2_nxt;
    logic [ALUOP_W-1:0]   r_alu_op, w_alu_op_nxt;
    logic                 r_we_br, w_we_br_nxt;
    logic [REG_AW-1:0]    r_br_waddr, w_br_waddr_nxt;
    logic                 r_ram_we, w_ram_we_nxt;
    logic [RAM_AW-1:0]    r_ram_addr, w_ram_addr_nxt;
    logic [DATA_W-1:0]    r_res_q, w_res_q_nxt;
    logic                 r_retire, w_retire_nxt;
    logic                 r_halted, w_halted_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;

    // In IDLE the incoming word is decoded so READ outputs are valid right after the transfer edge.
    assign w_dec_src = (r_state == ST_IDLE) ? instr : r_instr_q;

    isa_decode u_decode (
        .i_instr  (w_dec_src),
        .o_fields (w_fields)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_instr_q_nxt     = r_instr_q;
        w_op1_nxt         = r_op1;
        w_op2_nxt         = r_op2;
        w_alu_op_nxt      = r_alu_op;
        w_we_br_nxt       = 1'b0;
        w_br_waddr_nxt    = r_br_waddr;
        w_ram_we_nxt      = 1'b0;
        w_ram_addr_nxt    = r_ram_addr;
        w_res_q_nxt       = r_res_q;
        w_retire_nxt      = 1'b0;
        w_halted_nxt      = r_halted;
        w_cnt_nxt         = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (instr_valid && r_instr_ready) begin
                    w_instr_q_nxt = instr;
                    if (w_fields.cls == CLS_HALT) begin
                        w_state_nxt  = ST_HALT;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = ST_READ;
                        w_op1_nxt      = REG_AW'(w_fields.rs1);
                        w_op2_nxt      = REG_AW'(w_fields.rs2);
                        w_alu_op_nxt   = w_fields.alu_op;
                        w_br_waddr_nxt = REG_AW'(w_fields.rd);
                        w_ram_addr_nxt = RAM_AW'(w_fields.rd);
                    end
                end
            end
            ST_READ: begin
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                // Result capture, strobes and retire all land together on entry to WRITE.
                w_state_nxt  = ST_WRITE;
                w_res_q_nxt  = alu_result;
                w_we_br_nxt  = (w_fields.cls == CLS_ALU_BR);
                w_ram_we_nxt = (w_fields.cls == CLS_ALU_RAM);
                w_retire_nxt = 1'b1;
                w_cnt_nxt    = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
            end
            ST_WRITE: begin
                w_state_nxt  = ST_IDLE;
                w_op1_nxt    = '0;
                w_op2_nxt    = '0;
                w_alu_op_nxt = '0;
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_instr_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_q     <= '0;
            r_instr_ready <= 1'b1;
            r_op1         <= '0;
            r_op2         <= '0;
            r_alu_op      <= '0;
            r_we_br       <= 1'b0;
            r_br_waddr    <= '0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_res_q       <= '0;
            r_retire      <= 1'b0;
            r_halted      <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_instr_q     <= w_instr_q_nxt;
            r_instr_ready <= w_instr_ready_nxt;
            r_op1         <= w_op1_nxt;
            r_op2         <= w_op2_nxt;
            r_alu_op      <= w_alu_op_nxt;
            r_we_br       <= w_we_br_nxt;
            r_br_waddr    <= w_br_waddr_nxt;
            r_ram_we      <= w_ram_we_nxt;
            r_ram_addr    <= w_ram_addr_nxt;
            r_res_q       <= w_res_q_nxt;
            r_retire      <= w_retire_nxt;
            r_halted      <= w_halted_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign instr_ready = r_instr_ready;
    assign op1         = r_op1;
    assign op2         = r_op2;
    assign alu_op      = r_alu_op;
    assign we_br       = r_we_br;
    assign br_waddr    = r_br_waddr;
    assign ram_we      = r_ram_we;
    assign ram_addr    = r_ram_addr;
    assign wdata       = r_res_q;
    assign retire      = r_retire;
    assign halted      = r_halted;
    assign retired_cnt = r_cnt;

endmodule
